// File: rtl/frame_checker_if.sv
// ----------------------------------------------------------------------------
// frame_checker_if
//   Bundles the Avalon-MM register port and the ingress AXI-stream port of
//   frame_checker.
//
//   Avalon-MM : writedata[7:0], write, chipselect, address[7:0], read,
//               readdata[7:0] (driven by the checker)
//   AXI-stream: ingress_port_tdata[TDATA_W-1:0], ingress_port_tvalid,
//               ingress_port_tlast, ingress_port_tready (driven by the checker)
//
//   slave  : the frame_checker side
//   master : the host / stream-source side
// ----------------------------------------------------------------------------
interface frame_checker_if #(
    parameter int TDATA_W = 16
);
    logic [7:0]         writedata;
    logic               write;
    logic               chipselect;
    logic [7:0]         address;
    logic               read;
    logic [7:0]         readdata;

    logic [TDATA_W-1:0] ingress_port_tdata;
    logic               ingress_port_tvalid;
    logic               ingress_port_tready;
    logic               ingress_port_tlast;

    modport slave (
        input  writedata,
        input  write,
        input  chipselect,
        input  address,
        input  read,
        output readdata,
        input  ingress_port_tdata,
        input  ingress_port_tvalid,
        input  ingress_port_tlast,
        output ingress_port_tready
    );

    modport master (
        output writedata,
        output write,
        output chipselect,
        output address,
        output read,
        input  readdata,
        output ingress_port_tdata,
        output ingress_port_tvalid,
        output ingress_port_tlast,
        input  ingress_port_tready
    );
endinterface

// File: rtl/frame_checker.sv
// ----------------------------------------------------------------------------
// frame_checker
//   Ingress Ethernet frame checker. Compares the destination MAC of every
//   frame against up to four programmable filters, sums the payload into a
//   running checksum, counts accepted / dropped / runt frames and enforces a
//   programmable inter-frame gap by holding tready low.
//
//   Ports
//     clk      : single clock, rising edge
//     reset_n  : synchronous active-low reset
//     bus      : frame_checker_if.slave (Avalon-MM registers + AXI-stream in)
//
//   Register map (8-bit registers)
//     0x00+8*f+k : filter f, MAC byte k (k = 0..5)        RW
//     0x20       : FILT_EN, bit f enables filter f         RW
//     0x21       : IFG, gap cycles after every frame       RW
//     0x22       : CTRL, bit0 clear counters (pulse), bit1 promiscuous
//     0x30       : STATUS, [3:0] last accepted match vector, [7] busy
//     0x34..0x37 : LAST_CSUM, little-endian
//     0x38/39/3A : ACC_CNT / DROP_CNT / RUNT_CNT (saturating)
//
//   FSM states
//     state      | meaning
//     -----------+----------------------------------------------------------
//     ST_IDLE    | waiting for the first beat of a frame
//     ST_HDR     | inside the 14-byte header, destination MAC being matched
//     ST_PAYLOAD | frame matched; payload beats summed into the checksum
//     ST_DROP    | frame rejected; beats consumed until tlast
//     ST_WAIT    | inter-frame gap, tready held low
// ----------------------------------------------------------------------------
module frame_checker #(
    parameter int TDATA_W     = 16,
    parameter int NUM_FILTERS = 2,
    parameter int CSUM_W      = 32
) (
    input  logic           clk,
    input  logic           reset_n,
    frame_checker_if.slave bus
);

    localparam int BPB = TDATA_W / 8;   // bytes per beat

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HDR,
        ST_PAYLOAD,
        ST_DROP,
        ST_WAIT
    } state_t;

    state_t                 state_q, state_d;

    logic [7:0]             filt_mac [NUM_FILTERS][6];
    logic [NUM_FILTERS-1:0] filt_en;
    logic [7:0]             ifg;
    logic                   promisc;

    logic [3:0]             byte_cnt_q, byte_cnt_d;
    logic [NUM_FILTERS-1:0] match_q, match_d;
    logic [CSUM_W-1:0]      csum_q, csum_d;
    logic [CSUM_W-1:0]      last_csum;
    logic [3:0]             status_match;
    logic [7:0]             wait_cnt_q, wait_cnt_d;

    logic [7:0]             acc_cnt, drop_cnt, runt_cnt;
    logic [7:0]             readdata_q;

    logic [TDATA_W-1:0]     tdata;
    logic                   tvalid, tlast, tready, beat;

    logic                   wr_en, rd_en, clr_cnt;
    logic                   inc_acc, inc_drop, inc_runt, ld_last;

    logic [3:0]             cur_pos;
    logic [NUM_FILTERS-1:0] cmp_match;
    logic                   byte5_beat, hdr_end, drop_now;

    logic [CSUM_W-1:0]      tdata_ext;
    logic [31:0]            last_csum_ext;
    logic [3:0]             match_ext;
    logic [7:0]             filt_en_ext;
    logic [7:0]             rd_mux;

    assign tdata  = bus.ingress_port_tdata;
    assign tvalid = bus.ingress_port_tvalid;
    assign tlast  = bus.ingress_port_tlast;
    assign beat   = tvalid && tready;

    assign bus.ingress_port_tready = tready;
    assign bus.readdata            = readdata_q;

    assign wr_en   = bus.chipselect && bus.write;
    assign rd_en   = bus.chipselect && bus.read;
    assign clr_cnt = wr_en && (bus.address == 8'h22) && bus.writedata[0];

    // Zero-extensions done by assignment so no zero-width replication
    // appears when the widths happen to be equal.
    always_comb begin
        tdata_ext                  = '0;
        tdata_ext[TDATA_W-1:0]     = tdata;
        last_csum_ext              = '0;
        last_csum_ext[CSUM_W-1:0]  = last_csum;
        match_ext                  = '0;
        match_ext[NUM_FILTERS-1:0] = match_q;
        filt_en_ext                = '0;
        filt_en_ext[NUM_FILTERS-1:0] = filt_en;
    end

    // ------------------------------------------------------------------
    // Destination-MAC comparison for the beat currently on the bus.
    // The first beat of a frame is seen in IDLE, so its position is 0 and
    // the sticky match starts from all ones; disabled filters are masked
    // on every compared beat so a mid-frame FILT_EN clear takes effect.
    // ------------------------------------------------------------------
    always_comb begin
        cur_pos   = (state_q == ST_IDLE) ? 4'd0 : byte_cnt_q;
        cmp_match = ((state_q == ST_IDLE) ? {NUM_FILTERS{1'b1}} : match_q) & filt_en;
        for (int f = 0; f < NUM_FILTERS; f++) begin
            for (int i = 0; i < BPB; i++) begin
                if ((cur_pos + 4'(i)) < 4'd6) begin
                    if (tdata[8*i +: 8] != filt_mac[f][3'(cur_pos + 4'(i))]) begin
                        cmp_match[f] = 1'b0;
                    end
                end
            end
        end
        byte5_beat = (cur_pos == 4'(6 - BPB));
        hdr_end    = (cur_pos == 4'(14 - BPB));
        drop_now   = byte5_beat && (cmp_match == '0) && !promisc;
    end

    // ------------------------------------------------------------------
    // FSM next-state and datapath control
    // ------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        byte_cnt_d = byte_cnt_q;
        match_d    = match_q;
        csum_d     = csum_q;
        wait_cnt_d = wait_cnt_q;
        tready     = 1'b1;
        inc_acc    = 1'b0;
        inc_drop   = 1'b0;
        inc_runt   = 1'b0;
        ld_last    = 1'b0;

        case (state_q)
            ST_IDLE, ST_HDR: begin
                if (beat) begin
                    if (state_q == ST_IDLE) begin
                        csum_d = '0;
                    end
                    // Only beats touching bytes 0..5 update the match vector.
                    if (cur_pos < 4'd6) begin
                        match_d = cmp_match;
                    end
                    byte_cnt_d = cur_pos + 4'(BPB);
                    state_d    = ST_HDR;
                    if (tlast) begin
                        if (drop_now) begin
                            inc_drop = 1'b1;
                        end else begin
                            inc_runt = 1'b1;
                        end
                    end else if (drop_now) begin
                        state_d = ST_DROP;
                    end else if (hdr_end) begin
                        state_d = ST_PAYLOAD;
                    end
                end
            end

            ST_PAYLOAD: begin
                if (beat) begin
                    csum_d = csum_q + tdata_ext;
                    if (tlast) begin
                        ld_last = 1'b1;
                        inc_acc = 1'b1;
                    end
                end
            end

            ST_DROP: begin
                if (beat && tlast) begin
                    inc_drop = 1'b1;
                end
            end

            ST_WAIT: begin
                tready = 1'b0;
                if (wait_cnt_q <= 8'd1) begin
                    state_d = ST_IDLE;
                end else begin
                    wait_cnt_d = wait_cnt_q - 8'd1;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Common end-of-frame handling: gap length is sampled here, so an
        // IFG write during WAIT only affects the next frame.
        if (beat && tlast) begin
            if (ifg == 8'd0) begin
                state_d = ST_IDLE;
            end else begin
                state_d    = ST_WAIT;
                wait_cnt_d = ifg;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            byte_cnt_q <= '0;
            match_q    <= '0;
            csum_q     <= '0;
            wait_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            byte_cnt_q <= byte_cnt_d;
            match_q    <= match_d;
            csum_q     <= csum_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end

    // ------------------------------------------------------------------
    // Result registers and saturating counters; a clear beats an increment
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            last_csum    <= '0;
            status_match <= '0;
            acc_cnt      <= '0;
            drop_cnt     <= '0;
            runt_cnt     <= '0;
        end else begin
            if (ld_last) begin
                last_csum    <= csum_d;
                status_match <= match_ext;
            end
            if (clr_cnt) begin
                acc_cnt  <= '0;
                drop_cnt <= '0;
                runt_cnt <= '0;
            end else begin
                if (inc_acc && (acc_cnt != 8'hFF)) begin
                    acc_cnt <= acc_cnt + 8'd1;
                end
                if (inc_drop && (drop_cnt != 8'hFF)) begin
                    drop_cnt <= drop_cnt + 8'd1;
                end
                if (inc_runt && (runt_cnt != 8'hFF)) begin
                    runt_cnt <= runt_cnt + 8'd1;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Register file writes
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int f = 0; f < NUM_FILTERS; f++) begin
                for (int k = 0; k < 6; k++) begin
                    filt_mac[f][k] <= '0;
                end
            end
            filt_en <= '0;
            ifg     <= '0;
            promisc <= 1'b0;
        end else if (wr_en) begin
            for (int f = 0; f < NUM_FILTERS; f++) begin
                for (int k = 0; k < 6; k++) begin
                    if (bus.address == 8'(8*f + k)) begin
                        filt_mac[f][k] <= bus.writedata;
                    end
                end
            end
            case (bus.address)
                8'h20:   filt_en <= bus.writedata[NUM_FILTERS-1:0];
                8'h21:   ifg     <= bus.writedata;
                8'h22:   promisc <= bus.writedata[1];
                default: ;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Read mux and registered read data (zero unless a read was issued)
    // ------------------------------------------------------------------
    always_comb begin
        rd_mux = '0;
        if ((bus.address[7:5] == 3'b000) && (bus.address[2:0] < 3'd6) &&
            (int'(bus.address[4:3]) < NUM_FILTERS)) begin
            rd_mux = filt_mac[bus.address[4:3]][bus.address[2:0]];
        end else begin
            case (bus.address)
                8'h20:   rd_mux = filt_en_ext;
                8'h21:   rd_mux = ifg;
                8'h22:   rd_mux = {6'b0, promisc, 1'b0};
                8'h30:   rd_mux = {(state_q != ST_IDLE), 3'b0, status_match};
                8'h34:   rd_mux = last_csum_ext[7:0];
                8'h35:   rd_mux = last_csum_ext[15:8];
                8'h36:   rd_mux = last_csum_ext[23:16];
                8'h37:   rd_mux = last_csum_ext[31:24];
                8'h38:   rd_mux = acc_cnt;
                8'h39:   rd_mux = drop_cnt;
                8'h3A:   rd_mux = runt_cnt;
                default: rd_mux = '0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            readdata_q <= '0;
        end else if (rd_en) begin
            readdata_q <= rd_mux;
        end else begin
            readdata_q <= '0;
        end
    end

endmodule

// File: doc/frame_checker.md
FRAME_CHECKER -- requirements
Module: frame_checker

Interface
REQ-001 SHALL have parameter TDATA_W, default 16, ingress beat width in bits; legal values are 8 and 16.
REQ-002 SHALL have parameter NUM_FILTERS, default 2, number of destination-MAC filters; legal range is 1..4.
REQ-003 SHALL have parameter CSUM_W, default 32, payload checksum width; legal range is 16..32.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-005 SHALL have port reset_n, input, 1 bit: synchronous, active-low reset.
REQ-006 SHALL have Avalon slave ports writedata (in, 8), write (in, 1), chipselect (in, 1), address (in, 8), read (in, 1) and readdata (out, 8).
REQ-007 SHALL have ingress AXI-stream ports ingress_port_tdata (in, TDATA_W), ingress_port_tvalid (in, 1), ingress_port_tready (out, 1) and ingress_port_tlast (in, 1).

Function
REQ-008 Register map, write side: filter f MAC byte k (f < NUM_FILTERS, k = 0..5) at address 8*f+k; FILT_EN at 0x20 (bit f enables filter f); IFG at 0x21; CTRL at 0x22 (bit0 = clear counters, self-clearing; bit1 = promiscuous).
REQ-009 Register map, read side: all writable registers read back; STATUS at 0x30 ([3:0] match vector of last accepted frame, [7] busy); LAST_CSUM at 0x34..0x37, little-endian, zero-extended above CSUM_W; ACC_CNT at 0x38; DROP_CNT at 0x39; RUNT_CNT at 0x3A; any other address reads 0x00.
REQ-010 readdata SHALL be registered with 1-cycle latency, and SHALL be 0x00 in any cycle after which chipselect&&read was low.
REQ-011 A beat is accepted only when tvalid && tready are both high in the same cycle; nothing advances on any other cycle.
REQ-012 FSM states: IDLE, HDR, PAYLOAD, DROP, WAIT; tready = 1 in every state except WAIT.
REQ-013 The header is 14 bytes, i.e. 14*8/TDATA_W beats; a byte counter tracks position; bytes are in tdata little-endian, byte 0 in [7:0].
REQ-014 IDLE: the first accepted beat enters HDR; the checksum accumulator and match vector clear in the same cycle, and that beat is compared.
REQ-015 HDR, destination bytes 0..5: each enabled filter keeps a sticky match bit that stays 1 only while every byte compared so far equals its filter byte; disabled filters never match.
REQ-016 After byte 5: if no filter matches and promiscuous = 0, go to DROP; otherwise stay in HDR until byte 13 is done, then go to PAYLOAD.
REQ-017 PAYLOAD: checksum += zero-extended tdata for every accepted beat, including the tlast beat, with wrap modulo 2^CSUM_W.
REQ-018 tlast in PAYLOAD: LAST_CSUM <= final sum; STATUS match vector latched; ACC_CNT increments.
REQ-019 tlast in HDR (runt): RUNT_CNT increments; LAST_CSUM and STATUS unchanged.
REQ-020 tlast in DROP, or on the byte-5 beat of a non-matching frame: DROP_CNT increments.
REQ-021 After any tlast: if IFG = 0, go straight to IDLE (tready stays 1); otherwise load a wait counter with IFG and enter WAIT, decrementing each cycle and returning to IDLE on the cycle after it reaches 1 (exactly IFG cycles with tready = 0).
REQ-022 An IFG write takes effect only at the next load; a write during WAIT does not change the running count.
REQ-023 The counters are 8 bits and saturate at 0xFF.
REQ-024 A CTRL.bit0 write zeroes ACC_CNT, DROP_CNT and RUNT_CNT; if it coincides with an increment, the clear wins.
REQ-025 Filter or FILT_EN writes mid-frame affect comparisons from the next compared beat.
REQ-026 STATUS busy = 1 whenever the state is not IDLE.

Reset
REQ-027 While reset_n = 0 at a clock edge: state <= IDLE; all registers, counters, checksum, LAST_CSUM and STATUS <= 0; readdata <= 0x00.
REQ-028 tready SHALL be 1 during and immediately after reset, since IDLE is not WAIT.
REQ-029 Reset asserted mid-frame abandons the frame with no counter update; the remainder of that frame is treated as a new frame on resumption.

Verification
REQ-030 Filter0 = 02:00:00:00:00:01, FILT_EN = 0x01, IFG = 3; send a matching frame of 7 header beats + payload beats 0x0001, 0xFFFF, 0x0010 (tlast) -> LAST_CSUM = 0x00010010, ACC_CNT = 1, STATUS = 0x01, tready low for exactly 3 cycles.
REQ-031 Same setup, destination 02:00:00:00:00:02, 10-beat frame -> DROP_CNT = 1, ACC_CNT = 0, LAST_CSUM unchanged, all beats accepted.
REQ-032 tlast on header beat 4 -> RUNT_CNT = 1, no other counter changes; with IFG = 0, tready never drops.
REQ-033 Promiscuous = 1, FILT_EN = 0, any 8-beat frame -> ACC_CNT = 1, STATUS match vector = 0.
REQ-034 CSUM_W = 16, payload 0xFFFF, 0x0002 -> LAST_CSUM = 0x0001 (wrap); 256 matching frames -> ACC_CNT = 0xFF (saturates).
REQ-035 Counter clear in the same cycle as an accepting tlast -> ACC_CNT = 0; reset_n low mid-payload -> all counters 0 and state IDLE.
